// File: rtl/kbd_letter_scroller.sv
// PS/2 set-2 receiver feeding a right-entering scroll buffer of letters,
// time-multiplexed onto active-low digit anodes.
module kbd_letter_scroller #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int TIMEOUT     = 200000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              kbdclk,
    input  logic              kbddat,
    output logic [DIGITS-1:0] an,
    output logic [4:0]        digit_letter,
    output logic [4:0]        last_letter,
    output logic              letter_stb,
    output logic              frame_err
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK} state_t;

    function automatic logic [4:0] letter_of(input logic [7:0] c);
        case (c)
            8'h1C: letter_of = 5'd1;  8'h32: letter_of = 5'd2;  8'h21: letter_of = 5'd3;
            8'h23: letter_of = 5'd4;  8'h24: letter_of = 5'd5;  8'h2B: letter_of = 5'd6;
            8'h34: letter_of = 5'd7;  8'h33: letter_of = 5'd8;  8'h43: letter_of = 5'd9;
            8'h3B: letter_of = 5'd10; 8'h42: letter_of = 5'd11; 8'h4B: letter_of = 5'd12;
            8'h3A: letter_of = 5'd13; 8'h31: letter_of = 5'd14; 8'h44: letter_of = 5'd15;
            8'h4D: letter_of = 5'd16; 8'h15: letter_of = 5'd17; 8'h2D: letter_of = 5'd18;
            8'h1B: letter_of = 5'd19; 8'h2C: letter_of = 5'd20; 8'h3C: letter_of = 5'd21;
            8'h2A: letter_of = 5'd22; 8'h1D: letter_of = 5'd23; 8'h22: letter_of = 5'd24;
            8'h35: letter_of = 5'd25; 8'h1A: letter_of = 5'd26;
            default: letter_of = 5'd0;
        endcase
    endfunction

    logic             kc_s1_q, kc_s1_d, kc_s2_q, kc_s2_d, kc_prev_q, kc_prev_d;
    logic             kd_s1_q, kd_s1_d, kd_s2_q, kd_s2_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [9:0]       shreg_q, shreg_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       code_q, code_d;
    logic             code_rdy_q, code_rdy_d;
    logic             frame_err_q, frame_err_d;
    state_t           state_q, state_d;
    logic [7:0]       held_q, held_d;
    logic [4:0]       slot_q [DIGITS];
    logic [4:0]       slot_d [DIGITS];
    logic [4:0]       last_letter_q, last_letter_d;
    logic             letter_stb_q, letter_stb_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic       fall, frame_done, frame_ok;
    logic       do_push, do_bksp, do_esc;
    logic [4:0] code_letter;

    // Receiver: shreg collects start, data and parity; stop is live on the 11th edge.
    always_comb begin
        kc_s1_d   = kbdclk;
        kc_s2_d   = kc_s1_q;
        kc_prev_d = kc_s2_q;
        kd_s1_d   = kbddat;
        kd_s2_d   = kd_s1_q;
        fall       = kc_prev_q & ~kc_s2_q;
        frame_done = fall && (bit_cnt_q == 4'd10);
        frame_ok   = !shreg_q[0] && kd_s2_q && (^shreg_q[9:1]);
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        tmo_d      = tmo_q;
        code_d     = code_q;
        code_rdy_d  = frame_done && frame_ok;
        frame_err_d = frame_done && !frame_ok;
        if (fall) begin
            tmo_d     = '0;
            shreg_d   = {kd_s2_q, shreg_q[9:1]};
            bit_cnt_d = frame_done ? 4'd0 : bit_cnt_q + 4'd1;
            if (frame_done) code_d = shreg_q[8:1];
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            tmo_d     = '0;
            bit_cnt_d = 4'd0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (code_rdy_q) begin
            case (state_q)
                S_IDLE: begin
                    if (code_q == 8'hF0)      state_d = S_BREAK;
                    else if (code_q == 8'hE0) state_d = S_EXT;
                end
                S_EXT:   state_d = (code_q == 8'hF0) ? S_EXT_BREAK : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        code_letter = letter_of(code_q);
        do_push = 1'b0;
        do_bksp = 1'b0;
        do_esc  = 1'b0;
        held_d  = held_q;
        if (code_rdy_q) begin
            if (state_q == S_IDLE &&
                (code_letter != 5'd0 || code_q == 8'h66 || code_q == 8'h76)) begin
                held_d = code_q;
                if (code_q != held_q) begin
                    do_push = (code_letter != 5'd0);
                    do_bksp = (code_q == 8'h66);
                    do_esc  = (code_q == 8'h76);
                end
            end else if (state_q == S_BREAK && code_q == held_q) begin
                held_d = 8'h00;
            end
        end
    end

    always_comb begin
        slot_d        = slot_q;
        last_letter_d = last_letter_q;
        letter_stb_d  = do_push;
        if (do_push) begin
            for (int i = DIGITS - 1; i > 0; i--) slot_d[i] = slot_q[i-1];
            slot_d[0]     = code_letter;
            last_letter_d = code_letter;
        end else if (do_bksp) begin
            for (int i = 0; i < DIGITS - 1; i++) slot_d[i] = slot_q[i+1];
            slot_d[DIGITS-1] = 5'd0;
        end else if (do_esc) begin
            for (int i = 0; i < DIGITS; i++) slot_d[i] = 5'd0;
        end
        div_d = (div_q == DIV_W'(REFRESH_DIV - 1)) ? '0 : div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_W'(REFRESH_DIV - 1))
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kc_s1_q <= 1'b1; kc_s2_q <= 1'b1; kc_prev_q <= 1'b1;
            kd_s1_q <= 1'b1; kd_s2_q <= 1'b1;
            bit_cnt_q     <= 4'd0;
            shreg_q       <= '0;
            tmo_q         <= '0;
            code_q        <= 8'h00;
            code_rdy_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            state_q       <= S_IDLE;
            held_q        <= 8'h00;
            for (int i = 0; i < DIGITS; i++) slot_q[i] <= 5'd0;
            last_letter_q <= 5'd0;
            letter_stb_q  <= 1'b0;
            div_q         <= '0;
            idx_q         <= '0;
        end else begin
            kc_s1_q <= kc_s1_d; kc_s2_q <= kc_s2_d; kc_prev_q <= kc_prev_d;
            kd_s1_q <= kd_s1_d; kd_s2_q <= kd_s2_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            tmo_q         <= tmo_d;
            code_q        <= code_d;
            code_rdy_q    <= code_rdy_d;
            frame_err_q   <= frame_err_d;
            state_q       <= state_d;
            held_q        <= held_d;
            slot_q        <= slot_d;
            last_letter_q <= last_letter_d;
            letter_stb_q  <= letter_stb_d;
            div_q         <= div_d;
            idx_q         <= idx_d;
        end
    end

    // Blank slots keep their anode dark so unused digits stay off.
    always_comb begin
        an           = '1;
        digit_letter = slot_q[idx_q];
        if (slot_q[idx_q] != 5'd0) an[idx_q] = 1'b0;
    end

    assign last_letter = last_letter_q;
    assign letter_stb  = letter_stb_q;
    assign frame_err   = frame_err_q;
endmodule
